chip8_alu_sequencer: RTL and testbench
======================================

# chip8_alu_sequencer

Multi-cycle sequencer that executes Chip-8 register arithmetic and compare instructions by driving the combinational `Chip8_ALU`. It sits between the CPU decode stage and the V0–VF register file. It accepts one opcode per valid/ready handshake, then:
- reads Vx/Vy,
- issues one ALU operation,
- writes Vx and VF back, or reports a skip decision.

## Interface
- No parameters.
- `cpu_clk  in  1` — single clock; all state changes on its rising edge.
- `reset  in  1` — synchronous, active-high.
- `req_valid  in  1` — opcode present.
- `req_opcode  in  16` — full Chip-8 instruction.
- `req_ready  out  1` — high only in IDLE while reset is low.
- `rf_raddr_a  out  4` — register-file read address, port A (Vx).
- `rf_raddr_b  out  4` — read address, port B (Vy).
- `rf_rdata_a  in  8`, `rf_rdata_b  in  8` — synchronous read data, valid one cycle after the address.
- `rf_we  out  1`, `rf_waddr  out  4`, `rf_wdata  out  8` — register-file write port.
- `alu_in1  out  16`, `alu_in2  out  16`, `alu_sel  out  ALU_f` — ALU operands and function.
- `alu_out  in  16` — ALU result.
- `done  out  1` — one-cycle completion pulse.
- `skip  out  1` — valid with `done`; next instruction is skipped.
- `illegal  out  1` — valid with `done`; opcode is unsupported.

## Operation
- **States:** IDLE, RD, EX, WBX, WBF.
- **Accept:** when `req_valid && req_ready`, latch the opcode.
  - Decode x = [11:8], y = [7:4], kk = [7:0], N = [3:0].
  - `req_valid` outside IDLE is ignored.
- **Path by opcode class:**
  - Legal opcode: IDLE → RD.
  - Illegal opcode: IDLE → WBX with `illegal` = 1. No register read, no ALU use, no write.
- **RD:** drive `rf_raddr_a` = x and `rf_raddr_b` = y.
- **EX:**
  - Drive the ALU with zero-extended 8-bit operands.
  - Latch the result as `alu_out[7:0]`, plus the flag bit and skip bit.
- **WBX:**
  - Write Vx = result for arithmetic ops; no write for compares.
  - Pulse `done` if no flag write follows.
- **WBF:** write VF = flag and pulse `done`.
- **Return:** IDLE follows the `done` cycle.
- **Opcode map** (in1, in2 → Vx, VF):
  - 8xy0: OR(0, Vy) → Vx; no VF.
  - 8xy1 / 8xy2 / 8xy3: OR / AND / XOR(Vx, Vy) → Vx; no VF.
  - 8xy4: ADD(Vx, Vy); VF = `alu_out[8]`.
  - 8xy5: MINUS(Vx, Vy); VF = ~`alu_out[15]` (1 iff Vx ≥ Vy).
  - 8xy7: MINUS(Vy, Vx); VF = ~`alu_out[15]` (1 iff Vy ≥ Vx).
  - 8xy6: RSHIFT(Vx, 1); VF = Vx[0].
  - 8xyE: LSHIFT(Vx, 1); VF = Vx[7].
  - 7xkk: ADD(Vx, kk); no VF write. Carry is discarded; the result wraps mod 256.
  - 3xkk: EQUALS(Vx, kk); `skip` = `alu_out[0]`.
  - 4xkk: EQUALS(Vx, kk); `skip` = ~`alu_out[0]`.
  - 5xy0: EQUALS(Vx, Vy); `skip` = `alu_out[0]`.
  - 9xy0: EQUALS(Vx, Vy); `skip` = ~`alu_out[0]`.
  - Everything else is illegal, including 5xyN and 9xyN with N ≠ 0, and 8xyN with N ∉ {0–7, E}.
- **ALU idle drive:** outside EX, `alu_in1` = `alu_in2` = 0 and `alu_sel` = ALU_f_OR.
- **x = F with a flag op:** WBX writes the result to VF, then WBF overwrites it with the flag. The flag wins.
- **x = y:** legal; both read ports carry the same register.

## Timing
- **Reset values:**
  - `req_ready`, `done`, `skip`, `illegal`, `rf_we` = 0.
  - All addresses and `rf_wdata` = 0.
  - State = IDLE.
- **Reset mid-operation:** aborts the instruction. `rf_we` is forced 0 in the reset cycle, no `done` is produced, and `req_ready` = 1 on the first cycle after reset deasserts.
- **Latency**, with the handshake at edge T:
  - RD at T+1, EX at T+2, WBX at T+3.
  - `done` at T+3 for no-flag and compare ops; at T+4 for flag ops.
  - Illegal ops: `done` at T+1.
- **Throughput:** `req_ready` returns the cycle after `done`, so the next accept is at `done`+1.
- **Output validity:** `skip` and `illegal` are meaningful only while `done` = 1 and are 0 otherwise.
- **Write ordering:** at most one register write per cycle; Vx always precedes VF.

## Test plan
- **8xy4 ADD with carry.** V1 = 0xF0, V2 = 0x20, opcode 0x8124 → V1 = 0x10 at T+3, VF = 1 at T+4, `done` at T+4.
- **8xy5 borrow and 8xy7.** Start from V1 = 0x05, V2 = 0x07.
  - 0x8125 → V1 = 0xFE, VF = 0.
  - Then reset V1 = 0x07, V2 = 0x05 and issue 0x8127 → V1 = 0xFE, VF = 0.
- **Shifts.** V3 = 0x81.
  - 0x830E → V3 = 0x02, VF = 1.
  - 0x8306 on 0x81 → V3 = 0x40, VF = 1.
- **Compares.** V4 = 0x2A.
  - 0x342A → `done` at T+3, `skip` = 1, no `rf_we`.
  - 0x442A → `skip` = 0.
  - 0x5450 with V5 ≠ V4 → `skip` = 0.
  - 0x9450 → `skip` = 1.
- **Illegal and backpressure.**
  - 0x812F → `done` + `illegal` at T+1, no writes.
  - `req_valid` held high while busy → exactly one accept per instruction.
- **VF destination and reset abort.**
  - 0x8F14 with VF = 0xFF, V1 = 0x01 → final VF = 1.
  - Reset asserted in WBX → no write, `req_ready` = 1 one cycle after reset deasserts.

Source files
------------

// File: rtl/chip8_alu_sequencer.sv
// chip8_alu_sequencer
// Runs one Chip-8 register arithmetic or compare instruction over several
// cycles: read Vx/Vy, drive the external combinational ALU once, then write
// Vx and VF back or report a skip decision. Unsupported opcodes finish in a
// single cycle with the illegal flag set and touch nothing.
module chip8_alu_sequencer (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [15:0] req_opcode,
    output logic        req_ready,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    input  logic [7:0]  rf_rdata_a,
    input  logic [7:0]  rf_rdata_b,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output logic [2:0]  alu_sel,
    input  logic [15:0] alu_out,
    output logic        done,
    output logic        skip,
    output logic        illegal
);

    // ALU function encoding shared with Chip8_ALU
    localparam logic [2:0] ALU_f_OR     = 3'd0;
    localparam logic [2:0] ALU_f_AND    = 3'd1;
    localparam logic [2:0] ALU_f_XOR    = 3'd2;
    localparam logic [2:0] ALU_f_ADD    = 3'd3;
    localparam logic [2:0] ALU_f_MINUS  = 3'd4;
    localparam logic [2:0] ALU_f_RSHIFT = 3'd5;
    localparam logic [2:0] ALU_f_LSHIFT = 3'd6;
    localparam logic [2:0] ALU_f_EQUALS = 3'd7;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_WBX  = 3'd3;
    localparam logic [2:0] S_WBF  = 3'd4;

    logic [2:0]  r_state;
    logic [15:0] r_opcode;
    logic        r_illegal;
    logic [7:0]  r_result;
    logic        r_flag;
    logic        r_skip;

    logic [3:0]  w_class;
    logic [3:0]  w_x;
    logic [3:0]  w_y;
    logic [7:0]  w_kk;
    logic [3:0]  w_n;
    logic        w_writesX;
    logic        w_flagOp;
    logic        w_isCmp;
    logic [15:0] w_in1;
    logic [15:0] w_in2;
    logic [2:0]  w_sel;
    logic        w_flag;
    logic        w_skip;
    logic        w_unusedAluBits;

    // Only bits 15, 8 and 7:0 of the ALU result carry meaning here
    assign w_unusedAluBits = ^alu_out[14:9];

    function automatic logic isLegal(input logic [15:0] op);
        case (op[15:12])
            4'h3, 4'h4, 4'h7: isLegal = 1'b1;
            4'h5, 4'h9:       isLegal = (op[3:0] == 4'h0);
            4'h8:             isLegal = (op[3:0] <= 4'h7) || (op[3:0] == 4'hE);
            default:          isLegal = 1'b0;
        endcase
    endfunction

    assign w_class = r_opcode[15:12];
    assign w_x     = r_opcode[11:8];
    assign w_y     = r_opcode[7:4];
    assign w_kk    = r_opcode[7:0];
    assign w_n     = r_opcode[3:0];

    // Instruction class flags; an illegal opcode never writes, flags or skips
    always_comb begin
        w_writesX = !r_illegal && ((w_class == 4'h8) || (w_class == 4'h7));
        w_flagOp  = !r_illegal && (w_class == 4'h8) &&
                    ((w_n == 4'h4) || (w_n == 4'h5) || (w_n == 4'h6) ||
                     (w_n == 4'h7) || (w_n == 4'hE));
        w_isCmp   = !r_illegal && ((w_class == 4'h3) || (w_class == 4'h4) ||
                                   (w_class == 4'h5) || (w_class == 4'h9));
    end

    // Operand and function selection for the EX cycle
    always_comb begin
        w_in1 = 16'h0000;
        w_in2 = 16'h0000;
        w_sel = ALU_f_OR;
        case (w_class)
            4'h8: begin
                w_in1 = {8'h00, rf_rdata_a};
                w_in2 = {8'h00, rf_rdata_b};
                case (w_n)
                    4'h0: w_in1 = 16'h0000;
                    4'h1: w_sel = ALU_f_OR;
                    4'h2: w_sel = ALU_f_AND;
                    4'h3: w_sel = ALU_f_XOR;
                    4'h4: w_sel = ALU_f_ADD;
                    4'h5: w_sel = ALU_f_MINUS;
                    4'h7: begin
                        w_in1 = {8'h00, rf_rdata_b};
                        w_in2 = {8'h00, rf_rdata_a};
                        w_sel = ALU_f_MINUS;
                    end
                    4'h6: begin
                        w_in2 = 16'h0001;
                        w_sel = ALU_f_RSHIFT;
                    end
                    4'hE: begin
                        w_in2 = 16'h0001;
                        w_sel = ALU_f_LSHIFT;
                    end
                    default: ;
                endcase
            end
            4'h7: begin
                w_in1 = {8'h00, rf_rdata_a};
                w_in2 = {8'h00, w_kk};
                w_sel = ALU_f_ADD;
            end
            4'h3, 4'h4: begin
                w_in1 = {8'h00, rf_rdata_a};
                w_in2 = {8'h00, w_kk};
                w_sel = ALU_f_EQUALS;
            end
            4'h5, 4'h9: begin
                w_in1 = {8'h00, rf_rdata_a};
                w_in2 = {8'h00, rf_rdata_b};
                w_sel = ALU_f_EQUALS;
            end
            default: ;
        endcase
    end

    // Flag and skip derivation from the ALU result (shift flags come from Vx)
    always_comb begin
        w_flag = 1'b0;
        w_skip = 1'b0;
        case (w_class)
            4'h8: begin
                case (w_n)
                    4'h4:       w_flag = alu_out[8];
                    4'h5, 4'h7: w_flag = ~alu_out[15];
                    4'h6:       w_flag = rf_rdata_a[0];
                    4'hE:       w_flag = rf_rdata_a[7];
                    default:    w_flag = 1'b0;
                endcase
            end
            4'h3, 4'h5: w_skip = alu_out[0];
            4'h4, 4'h9: w_skip = ~alu_out[0];
            default: ;
        endcase
    end

    // Sequencer state, opcode capture and result latching
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_opcode  <= 16'h0000;
            r_illegal <= 1'b0;
            r_result  <= 8'h00;
            r_flag    <= 1'b0;
            r_skip    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_opcode  <= req_opcode;
                        r_illegal <= !isLegal(req_opcode);
                        r_state   <= isLegal(req_opcode) ? S_RD : S_WBX;
                    end
                end
                S_RD: r_state <= S_EX;
                S_EX: begin
                    r_result <= alu_out[7:0];
                    r_flag   <= w_flag;
                    r_skip   <= w_skip;
                    r_state  <= S_WBX;
                end
                S_WBX:   r_state <= w_flagOp ? S_WBF : S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output decode; reset holds every output at its quiet value
    always_comb begin
        req_ready  = 1'b0;
        rf_raddr_a = 4'h0;
        rf_raddr_b = 4'h0;
        rf_we      = 1'b0;
        rf_waddr   = 4'h0;
        rf_wdata   = 8'h00;
        alu_in1    = 16'h0000;
        alu_in2    = 16'h0000;
        alu_sel    = ALU_f_OR;
        done       = 1'b0;
        skip       = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: req_ready = 1'b1;
                S_RD: begin
                    rf_raddr_a = w_x;
                    rf_raddr_b = w_y;
                end
                S_EX: begin
                    alu_in1 = w_in1;
                    alu_in2 = w_in2;
                    alu_sel = w_sel;
                end
                S_WBX: begin
                    rf_we = w_writesX;
                    if (w_writesX) begin
                        rf_waddr = w_x;
                        rf_wdata = r_result;
                    end
                    done    = !w_flagOp;
                    skip    = w_isCmp && r_skip;
                    illegal = r_illegal;
                end
                S_WBF: begin
                    rf_we    = 1'b1;
                    rf_waddr = 4'hF;
                    rf_wdata = {7'b0000000, r_flag};
                    done     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// tb_chip8_alu_sequencer
// Directed bench: a register-file model with synchronous reads and a
// behavioural Chip8_ALU surround the sequencer; each instruction is traced
// cycle by cycle relative to its handshake edge and compared against
// hand-computed writes, done timing and skip/illegal results.
module tb_chip8_alu_sequencer;

    localparam logic [2:0] ALU_f_OR     = 3'd0;
    localparam logic [2:0] ALU_f_AND    = 3'd1;
    localparam logic [2:0] ALU_f_XOR    = 3'd2;
    localparam logic [2:0] ALU_f_ADD    = 3'd3;
    localparam logic [2:0] ALU_f_MINUS  = 3'd4;
    localparam logic [2:0] ALU_f_RSHIFT = 3'd5;
    localparam logic [2:0] ALU_f_LSHIFT = 3'd6;
    localparam logic [2:0] ALU_f_EQUALS = 3'd7;

    logic        cpu_clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_opcode = 16'h0000;
    logic        req_ready;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic [7:0]  rf_rdata_a;
    logic [7:0]  rf_rdata_b;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [2:0]  alu_sel;
    logic [15:0] alu_out;
    logic        done;
    logic        skip;
    logic        illegal;

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0]  rfMem [16];
    logic        tbWe = 1'b0;
    logic [3:0]  tbAddr = 4'h0;
    logic [7:0]  tbData = 8'h00;

    int          obsDoneAt;
    logic        obsSkip;
    logic        obsIllegal;
    int          obsWrites;
    int          busyReady;
    int          spurious;
    logic        obsReadyAfter;
    logic [2:0]  obsSel;
    logic [15:0] obsIn1;
    logic [15:0] obsIn2;
    logic [3:0]  wrAddr [4];
    logic [7:0]  wrData [4];
    int          wrAt [4];

    chip8_alu_sequencer dut (
        .cpu_clk    (cpu_clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_opcode (req_opcode),
        .req_ready  (req_ready),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .done       (done),
        .skip       (skip),
        .illegal    (illegal)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Register file: synchronous read, bench preload port has priority
    always @(posedge cpu_clk) begin
        rf_rdata_a <= rfMem[rf_raddr_a];
        rf_rdata_b <= rfMem[rf_raddr_b];
        if (tbWe) rfMem[tbAddr] <= tbData;
        else if (rf_we) rfMem[rf_waddr] <= rf_wdata;
    end

    // Behavioural Chip8_ALU
    always_comb begin
        case (alu_sel)
            ALU_f_OR:     alu_out = alu_in1 | alu_in2;
            ALU_f_AND:    alu_out = alu_in1 & alu_in2;
            ALU_f_XOR:    alu_out = alu_in1 ^ alu_in2;
            ALU_f_ADD:    alu_out = alu_in1 + alu_in2;
            ALU_f_MINUS:  alu_out = alu_in1 - alu_in2;
            ALU_f_RSHIFT: alu_out = alu_in1 >> alu_in2;
            ALU_f_LSHIFT: alu_out = alu_in1 << alu_in2;
            default:      alu_out = {15'h0000, alu_in1 == alu_in2};
        endcase
    end

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic setReg(input logic [3:0] a, input logic [7:0] d);
        @(negedge cpu_clk);
        tbWe = 1'b1;
        tbAddr = a;
        tbData = d;
        @(negedge cpu_clk);
        tbWe = 1'b0;
    endtask

    // Issue one opcode and trace cycles k = 1.. after the handshake edge
    task automatic applyStimulus(input logic [15:0] op, input bit holdValid);
        obsDoneAt = 0;
        obsSkip = 1'b0;
        obsIllegal = 1'b0;
        obsWrites = 0;
        busyReady = 0;
        spurious = 0;
        obsReadyAfter = 1'b0;
        obsSel = 3'd0;
        obsIn1 = 16'h0000;
        obsIn2 = 16'h0000;
        @(negedge cpu_clk);
        req_valid = 1'b1;
        req_opcode = op;
        checkOutput($sformatf("ready_before_%h", op), 16'(req_ready), 16'h0001);
        @(posedge cpu_clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge cpu_clk);
            if (!holdValid) req_valid = 1'b0;
            if (obsDoneAt != 0) begin
                obsReadyAfter = req_ready;
                req_valid = 1'b0;
                break;
            end
            if (k == 2) begin
                obsSel = alu_sel;
                obsIn1 = alu_in1;
                obsIn2 = alu_in2;
            end
            if (rf_we && obsWrites < 4) begin
                wrAddr[obsWrites] = rf_waddr;
                wrData[obsWrites] = rf_wdata;
                wrAt[obsWrites] = k;
                obsWrites++;
            end
            if (req_ready) busyReady++;
            if (done) begin
                obsDoneAt = k;
                obsSkip = skip;
                obsIllegal = illegal;
            end else if (skip || illegal) begin
                spurious++;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic checkCommon(input string tag, input int expDone, input int expWrites);
        checkOutput({tag, "_doneAt"}, 16'(obsDoneAt), 16'(expDone));
        checkOutput({tag, "_writes"}, 16'(obsWrites), 16'(expWrites));
        checkOutput({tag, "_readyAfter"}, 16'(obsReadyAfter), 16'h0001);
        checkOutput({tag, "_busyReady"}, 16'(busyReady), 16'h0000);
        checkOutput({tag, "_spurious"}, 16'(spurious), 16'h0000);
    endtask

    task automatic checkWrite(input string tag, input int idx, input logic [3:0] a,
                              input logic [7:0] d, input int at);
        checkOutput($sformatf("%s_w%0d_addr", tag, idx), 16'(wrAddr[idx]), 16'(a));
        checkOutput($sformatf("%s_w%0d_data", tag, idx), 16'(wrData[idx]), 16'(d));
        checkOutput($sformatf("%s_w%0d_cycle", tag, idx), 16'(wrAt[idx]), 16'(at));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge cpu_clk);
        @(negedge cpu_clk);
        checkOutput("rst_ready", 16'(req_ready), 16'h0000);
        checkOutput("rst_done", 16'(done), 16'h0000);
        checkOutput("rst_we", 16'(rf_we), 16'h0000);
        checkOutput("rst_raddr_a", 16'(rf_raddr_a), 16'h0000);
        checkOutput("rst_waddr", 16'(rf_waddr), 16'h0000);
        checkOutput("rst_wdata", 16'(rf_wdata), 16'h0000);
        checkOutput("rst_skip_illegal", 16'({skip, illegal}), 16'h0000);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_ready", 16'(req_ready), 16'h0001);
        checkOutput("idle_alu_sel", 16'(alu_sel), 16'(ALU_f_OR));
        checkOutput("idle_alu_in", alu_in1 | alu_in2, 16'h0000);

        // 8124: 0xF0 + 0x20 = 0x110 -> V1 = 0x10, VF = 1
        setReg(4'h1, 8'hF0);
        setReg(4'h2, 8'h20);
        applyStimulus(16'h8124, 1'b0);
        checkCommon("add", 4, 2);
        checkWrite("add", 0, 4'h1, 8'h10, 3);
        checkWrite("add", 1, 4'hF, 8'h01, 4);
        checkOutput("add_sel", 16'(obsSel), 16'(ALU_f_ADD));
        checkOutput("add_illegal", 16'(obsIllegal), 16'h0000);
        checkOutput("add_rf_v1", 16'(rfMem[1]), 16'h0010);

        // 8125: 0x05 - 0x07 borrows -> V1 = 0xFE, VF = 0
        setReg(4'h1, 8'h05);
        setReg(4'h2, 8'h07);
        applyStimulus(16'h8125, 1'b0);
        checkCommon("sub", 4, 2);
        checkWrite("sub", 0, 4'h1, 8'hFE, 3);
        checkWrite("sub", 1, 4'hF, 8'h00, 4);

        // 8127: Vy - Vx = 0x05 - 0x07 -> V1 = 0xFE, VF = 0, operands swapped
        setReg(4'h1, 8'h07);
        setReg(4'h2, 8'h05);
        applyStimulus(16'h8127, 1'b0);
        checkCommon("subn", 4, 2);
        checkWrite("subn", 0, 4'h1, 8'hFE, 3);
        checkWrite("subn", 1, 4'hF, 8'h00, 4);
        checkOutput("subn_in1", obsIn1, 16'h0005);
        checkOutput("subn_in2", obsIn2, 16'h0007);
        checkOutput("subn_sel", 16'(obsSel), 16'(ALU_f_MINUS));

        // Shifts of 0x81
        setReg(4'h3, 8'h81);
        applyStimulus(16'h830E, 1'b0);
        checkCommon("shl", 4, 2);
        checkWrite("shl", 0, 4'h3, 8'h02, 3);
        checkWrite("shl", 1, 4'hF, 8'h01, 4);
        setReg(4'h3, 8'h81);
        applyStimulus(16'h8306, 1'b0);
        checkCommon("shr", 4, 2);
        checkWrite("shr", 0, 4'h3, 8'h40, 3);
        checkWrite("shr", 1, 4'hF, 8'h01, 4);

        // 8720: V7 = 0 | V2 (0x05), no flag
        applyStimulus(16'h8720, 1'b0);
        checkCommon("mov", 3, 1);
        checkWrite("mov", 0, 4'h7, 8'h05, 3);
        checkOutput("mov_in1", obsIn1, 16'h0000);

        // 7620: 0xF0 + 0x20 wraps to 0x10, VF untouched
        setReg(4'h6, 8'hF0);
        applyStimulus(16'h7620, 1'b0);
        checkCommon("addi", 3, 1);
        checkWrite("addi", 0, 4'h6, 8'h10, 3);

        // Compares with V4 = 0x2A, V5 = 0x11
        setReg(4'h4, 8'h2A);
        setReg(4'h5, 8'h11);
        applyStimulus(16'h342A, 1'b0);
        checkCommon("se_imm", 3, 0);
        checkOutput("se_imm_skip", 16'(obsSkip), 16'h0001);
        applyStimulus(16'h442A, 1'b0);
        checkCommon("sne_imm", 3, 0);
        checkOutput("sne_imm_skip", 16'(obsSkip), 16'h0000);
        applyStimulus(16'h5450, 1'b0);
        checkCommon("se_reg", 3, 0);
        checkOutput("se_reg_skip", 16'(obsSkip), 16'h0000);
        applyStimulus(16'h9450, 1'b1);
        checkCommon("sne_reg_hold", 3, 0);
        checkOutput("sne_reg_skip", 16'(obsSkip), 16'h0001);

        // Illegal opcodes with req_valid held high
        applyStimulus(16'h812F, 1'b1);
        checkCommon("ill_8", 1, 0);
        checkOutput("ill_8_flag", 16'(obsIllegal), 16'h0001);
        applyStimulus(16'h5451, 1'b1);
        checkCommon("ill_5", 1, 0);
        checkOutput("ill_5_flag", 16'(obsIllegal), 16'h0001);
        checkOutput("ill_5_skip", 16'(obsSkip), 16'h0000);

        // 8F14 with VF = 0xFF, V1 = 0x01: sum 0x00 to VF, then carry wins
        setReg(4'hF, 8'hFF);
        setReg(4'h1, 8'h01);
        applyStimulus(16'h8F14, 1'b0);
        checkCommon("vfdst", 4, 2);
        checkWrite("vfdst", 0, 4'hF, 8'h00, 3);
        checkWrite("vfdst", 1, 4'hF, 8'h01, 4);
        checkOutput("vfdst_final", 16'(rfMem[15]), 16'h0001);

        // Reset asserted during WBX aborts the write
        setReg(4'h1, 8'h33);
        setReg(4'h2, 8'h44);
        @(negedge cpu_clk);
        req_valid = 1'b1;
        req_opcode = 16'h8124;
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        req_valid = 1'b0;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_we", 16'(rf_we), 16'h0000);
        checkOutput("abort_done", 16'(done), 16'h0000);
        checkOutput("abort_ready", 16'(req_ready), 16'h0000);
        @(negedge cpu_clk);
        reset = 1'b0;
        #1;
        checkOutput("abort_ready_after", 16'(req_ready), 16'h0001);
        @(negedge cpu_clk);
        checkOutput("abort_v1", 16'(rfMem[1]), 16'h0033);
        checkOutput("abort_vf", 16'(rfMem[15]), 16'h0001);
        checkOutput("abort_idle_done", 16'(done), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
